fpu_ss_issue_arbiter: RTL and testbench
=======================================

# fpu_ss_issue_arbiter

Round-robin arbiter that lets NB_CORES cluster cores share one fpu_ss instance. It sits directly upstream of the fpu_ss issue interface. It selects one requesting core per issue handshake, forwards that core's request payload, and returns the fpu_ss issue response to the granted core only. It also drives the granted core index into fpu_ss `core_id_i`. The grant is locked while fpu_ss back-pressures, so the forwarded request stays stable until accepted.

## Interface
Parameters:
- NB_CORES, 8, number of requesting cores; any value ≥2.
- REQ_W, 128, width of one opaque issue request payload.
- RESP_W, 8, width of the opaque issue response payload.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  reset, synchronous and active-low.
- core_valid_i  in  NB_CORES  per-core issue valid.
- core_ready_o  out  NB_CORES  per-core issue ready; at most one bit set.
- core_req_i  in  NB_CORES*REQ_W  per-core payloads; core k occupies bits [k*REQ_W +: REQ_W].
- core_resp_o  out  RESP_W  issue response; meaningful only for the core whose core_ready_o bit is set.
- x_issue_valid_o  out  1  issue valid to fpu_ss.
- x_issue_ready_i  in  1  issue ready from fpu_ss.
- x_issue_req_o  out  REQ_W  payload of the granted core.
- x_issue_resp_i  in  RESP_W  issue response from fpu_ss.
- core_id_o  out  32  granted core index, zero-extended; drives fpu_ss core_id_i.
- grant_cnt_o  out  NB_CORES*16  per-core accepted-issue counters (see Configuration).

## Operation
- State: `IDLE` or `LOCKED`.
  - Holding registers: `lock_idx`, and round-robin pointer `rr_ptr`, width $clog2(NB_CORES).
- Candidate selection:
  - In `IDLE`: the first core with core_valid_i set, searching from `rr_ptr` upward with modulo-NB_CORES wrap. This is combinational, giving zero-cycle grant.
  - In `LOCKED`: the candidate is `lock_idx`.
- Output signals:
  - x_issue_valid_o = core_valid_i[cand]; 0 if no candidate.
  - x_issue_req_o = core_req_i slice of cand; all-zero when x_issue_valid_o=0.
  - core_id_o = cand; 0 when no candidate.
  - core_ready_o[cand] = x_issue_ready_i; all other bits 0.
  - core_resp_o = x_issue_resp_i, passed through.
- Handshake = x_issue_valid_o & x_issue_ready_i.
  - On handshake: `rr_ptr` ← (cand+1) mod NB_CORES; state → `IDLE`.
- Valid without ready, in `IDLE`: `lock_idx` ← cand; state → `LOCKED`.
- `LOCKED` with core_valid_i[lock_idx]=0 (request withdrawn): x_issue_valid_o=0 that cycle; state → `IDLE`; `rr_ptr` unchanged.
- New requests from other cores during `LOCKED` are ignored until release.
- No request: outputs idle; state and `rr_ptr` hold.

## Timing
- Reset (rst_ni=0 at a clk_i edge) → state `IDLE`, `rr_ptr`=0, counters 0.
- While rst_ni=0, outputs are forced: x_issue_valid_o=0, core_ready_o=0, core_id_o=0, x_issue_req_o=0.
- Reset asserted mid-lock: the lock is dropped. After release, arbitration restarts from core 0 whether or not the previously locked core is still valid.
- Latency: request visible on x_issue_* in the same cycle as core_valid_i (IDLE). There are no pipeline registers on the data path.
- Throughput: one handshake per cycle. Consecutive handshakes rotate fairly among continuously-valid cores.
- x_issue_req_o and core_id_o are stable from first valid until handshake. The only exception is the withdrawal case.
- Simultaneous handshake and new requests: the next grant is computed from the updated `rr_ptr` in the following cycle.
- `rr_ptr` wrap: NB_CORES-1 → 0.

## Configuration
- Macro `FPU_SS_ARB_STATS_EN`.
- Defined:
  - One 16-bit counter per core, incremented on each handshake granted to that core.
  - Counters saturate at 0xFFFF.
  - Counters are cleared by reset.
  - Exposed on grant_cnt_o, core k at [k*16 +: 16].
- Undefined: no counter flops; grant_cnt_o tied to all-zero. The port is present in both builds.

## Test plan
- Reset then core 2 valid, x_issue_ready_i=1 → same cycle: x_issue_valid_o=1, core_id_o=2, core_ready_o=0x04, payload matches core 2. Next cycle `rr_ptr`=3.
- All 8 cores valid, ready=1 for 10 cycles from reset → grant order 0,1,…,7,0,1. core_ready_o is one-hot every cycle.
- Cores 1 and 5 valid, ready=0 for 4 cycles, then 1 → core_id_o=1 and payload held for all 5 cycles despite core 5. Grant moves to 5 the next cycle.
- Locked on core 3, core 3 drops valid → x_issue_valid_o=0 that cycle. The next cycle grants the next valid core at or after `rr_ptr` (not after 3).
- rst_ni=0 for 1 cycle while locked on core 6 with core 6 still valid → after release, core 0 (if valid) is granted first. grant_cnt_o is all-zero.
- With FPU_SS_ARB_STATS_EN defined, core 4 alone issues 65537 handshakes → grant_cnt_o[4*16 +: 16]=0xFFFF, others 0. Without the macro, grant_cnt_o=0 throughout.

Source files
------------

// File: rtl/fpu_ss_issue_arbiter_if.sv
// Issue-side bundle between NB_CORES requesting cores, the arbiter and one fpu_ss.
// master = arbiter view, slave = cores/fpu_ss environment view.
interface fpu_ss_issue_arbiter_if #(
    parameter int NB_CORES = 8,
    parameter int REQ_W    = 128,
    parameter int RESP_W   = 8
);
    logic [NB_CORES-1:0]       core_valid_i;
    logic [NB_CORES-1:0]       core_ready_o;
    logic [NB_CORES*REQ_W-1:0] core_req_i;
    logic [RESP_W-1:0]         core_resp_o;
    logic                      x_issue_valid_o;
    logic                      x_issue_ready_i;
    logic [REQ_W-1:0]          x_issue_req_o;
    logic [RESP_W-1:0]         x_issue_resp_i;
    logic [31:0]               core_id_o;
    logic [NB_CORES*16-1:0]    grant_cnt_o;

    modport master (
        input  core_valid_i, core_req_i, x_issue_ready_i, x_issue_resp_i,
        output core_ready_o, core_resp_o, x_issue_valid_o, x_issue_req_o,
               core_id_o, grant_cnt_o
    );

    modport slave (
        output core_valid_i, core_req_i, x_issue_ready_i, x_issue_resp_i,
        input  core_ready_o, core_resp_o, x_issue_valid_o, x_issue_req_o,
               core_id_o, grant_cnt_o
    );
endinterface

// File: rtl/fpu_ss_issue_arbiter.sv
// Round-robin issue arbiter sharing one fpu_ss among NB_CORES cores; grant locks under back-pressure.
// Optional per-core accepted-issue counters enabled by macro FPU_SS_ARB_STATS_EN.
module fpu_ss_issue_arbiter #(
    parameter int NB_CORES = 8,
    parameter int REQ_W    = 128,
    parameter int RESP_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    fpu_ss_issue_arbiter_if.master bus
);
    localparam int PTR_W = $clog2(NB_CORES);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [PTR_W-1:0]   lock_idx_reg, lock_idx_next;

    logic               search_found;
    logic [PTR_W-1:0]   search_idx;
    logic [PTR_W:0]     search_sum;
    logic               has_cand;
    logic [PTR_W-1:0]   cand;
    logic               cand_valid;
    logic               handshake;
    logic [REQ_W-1:0]   req_arr [NB_CORES];

    for (genvar gi = 0; gi < NB_CORES; gi++) begin : g_req_split
        assign req_arr[gi] = bus.core_req_i[gi*REQ_W +: REQ_W];
    end

    // First valid core at or above rr_ptr, wrapping modulo NB_CORES.
    always_comb begin
        search_found = 1'b0;
        search_idx   = '0;
        search_sum   = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            search_sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(i);
            if (search_sum >= (PTR_W+1)'(NB_CORES))
                search_sum = search_sum - (PTR_W+1)'(NB_CORES);
            if (!search_found && bus.core_valid_i[search_sum[PTR_W-1:0]]) begin
                search_found = 1'b1;
                search_idx   = search_sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        lock_idx_next = lock_idx_reg;
        has_cand      = 1'b0;
        cand          = '0;
        cand_valid    = 1'b0;
        case (state_reg)
            IDLE: begin
                has_cand   = search_found;
                cand       = search_idx;
                cand_valid = search_found;
                if (cand_valid && !bus.x_issue_ready_i) begin
                    lock_idx_next = cand;
                    state_next    = LOCKED;
                end
            end
            LOCKED: begin
                has_cand   = 1'b1;
                cand       = lock_idx_reg;
                cand_valid = bus.core_valid_i[lock_idx_reg];
                // Withdrawal or acceptance both release the lock.
                if (!cand_valid || bus.x_issue_ready_i)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (cand_valid && bus.x_issue_ready_i)
            rr_ptr_next = (cand == PTR_W'(NB_CORES-1)) ? '0 : cand + 1'b1;
    end

    assign handshake = cand_valid & bus.x_issue_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            lock_idx_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            lock_idx_reg <= lock_idx_next;
        end
    end

    // Outputs are forced quiet while reset is held low.
    assign bus.x_issue_valid_o = rst_ni & cand_valid;
    assign bus.x_issue_req_o   = (rst_ni && cand_valid) ? req_arr[cand] : '0;
    assign bus.core_id_o       = (rst_ni && has_cand) ? 32'(cand) : 32'd0;
    assign bus.core_resp_o     = bus.x_issue_resp_i;

    always_comb begin
        bus.core_ready_o = '0;
        if (rst_ni && has_cand)
            bus.core_ready_o[cand] = bus.x_issue_ready_i;
    end

    logic [NB_CORES*16-1:0] grant_cnt;

`ifdef FPU_SS_ARB_STATS_EN
    for (genvar gi = 0; gi < NB_CORES; gi++) begin : g_stats
        logic [15:0] cnt_reg;
        always_ff @(posedge clk_i) begin
            if (!rst_ni)
                cnt_reg <= '0;
            else if (handshake && cand == PTR_W'(gi) && cnt_reg != 16'hFFFF)
                cnt_reg <= cnt_reg + 16'd1;
        end
        assign grant_cnt[gi*16 +: 16] = cnt_reg;
    end
`else
    assign grant_cnt = '0;
`endif

    assign bus.grant_cnt_o = grant_cnt;
endmodule

// File: tb/tb_fpu_ss_issue_arbiter.sv
// Table-driven directed bench for fpu_ss_issue_arbiter plus hand-written lock and saturation sequences.
module tb_fpu_ss_issue_arbiter;
    localparam int N = 8;

    typedef struct {
        logic       rst_n;
        logic [7:0] valid;
        logic       ready;
        logic       exp_valid;
        logic       chk_id;
        int         exp_id;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   cnt_model [N];
    vec_t vecs [$];

    fpu_ss_issue_arbiter_if #(.NB_CORES(N), .REQ_W(128), .RESP_W(8)) bus ();

    fpu_ss_issue_arbiter #(.NB_CORES(N), .REQ_W(128), .RESP_W(8)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] payload(input int k);
        return {4{32'hC0DE_0000 + 32'(k)}};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic r, input logic [7:0] v, input logic rdy,
                       input logic ev, input logic ck, input int id);
        vec_t t;
        t.rst_n = r; t.valid = v; t.ready = rdy;
        t.exp_valid = ev; t.chk_id = ck; t.exp_id = id;
        vecs.push_back(t);
    endtask

    function automatic logic [127:0] cnt_expect();
        logic [127:0] e;
        e = '0;
        for (int k = 0; k < N; k++) e[k*16 +: 16] = 16'(cnt_model[k]);
        return e;
    endfunction

    task automatic drive(input logic r, input logic [7:0] v, input logic rdy, input logic [7:0] resp);
        @(posedge clk);
        #1;
        rst_n = r;
        bus.core_valid_i = v;
        bus.x_issue_ready_i = rdy;
        bus.x_issue_resp_i = resp;
        #1;
    endtask

    initial begin
        logic [7:0]   er;
        logic [127:0] ereq;
        logic [7:0]   resp;

        bus.core_valid_i = '0;
        bus.x_issue_ready_i = 1'b0;
        bus.x_issue_resp_i = '0;
        for (int k = 0; k < N; k++) begin
            bus.core_req_i[k*128 +: 128] = payload(k);
            cnt_model[k] = 0;
        end

        //  rst valid   rdy ev chk id
        add(0, 8'hFF, 1, 0, 1, 0);   // outputs forced during reset
        add(1, 8'h04, 1, 1, 1, 2);   // zero-cycle grant of core 2
        add(1, 8'h0C, 1, 1, 1, 3);   // rr_ptr now 3
        add(1, 8'h0C, 1, 1, 1, 2);   // wrap search from 4
        add(1, 8'h00, 1, 0, 1, 0);   // no request
        add(0, 8'hFF, 1, 0, 1, 0);
        for (int i = 0; i < 10; i++) add(1, 8'hFF, 1, 1, 1, i % 8);
        add(0, 8'h00, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(1, 8'h22, 0, 1, 1, 1);  // locked on 1 despite 5
        add(1, 8'h22, 1, 1, 1, 1);
        add(1, 8'h28, 0, 1, 1, 3);   // lock on 3, rr_ptr=2
        add(1, 8'h20, 0, 0, 0, 0);   // core 3 withdraws
        add(1, 8'h25, 1, 1, 1, 2);   // restart from rr_ptr=2, not after 3
        add(1, 8'h80, 0, 1, 1, 7);
        add(1, 8'h88, 0, 1, 1, 7);   // newcomer 3 ignored while locked
        add(1, 8'h88, 1, 1, 1, 7);   // rr_ptr wraps to 0
        add(1, 8'h88, 1, 1, 1, 3);
        add(1, 8'h41, 0, 1, 1, 6);   // lock on 6
        add(0, 8'h41, 0, 0, 1, 0);   // reset mid-lock
        add(1, 8'h41, 1, 1, 1, 0);   // restart at core 0

        drive(0, 8'h00, 0, 8'h00);
        drive(0, 8'h00, 0, 8'h00);

        foreach (vecs[i]) begin
            resp = 8'(8'h30 + i);
            drive(vecs[i].rst_n, vecs[i].valid, vecs[i].ready, resp);
            er = '0;
            if (vecs[i].exp_valid) er[vecs[i].exp_id] = vecs[i].ready;
            ereq = vecs[i].exp_valid ? payload(vecs[i].exp_id) : 128'd0;
            $display("row %0d: rst_n=%0b valid=%h ready=%0b -> x_valid=%0b id=%0d core_ready=%h",
                     i, vecs[i].rst_n, vecs[i].valid, vecs[i].ready,
                     bus.x_issue_valid_o, bus.core_id_o, bus.core_ready_o);
            check($sformatf("row%0d x_issue_valid", i), 128'(bus.x_issue_valid_o), 128'(vecs[i].exp_valid));
            check($sformatf("row%0d x_issue_req", i), bus.x_issue_req_o, ereq);
            check($sformatf("row%0d core_resp", i), 128'(bus.core_resp_o), 128'(resp));
            check($sformatf("row%0d grant_cnt", i), bus.grant_cnt_o, cnt_expect());
            if (vecs[i].chk_id) begin
                check($sformatf("row%0d core_id", i), 128'(bus.core_id_o), 128'(vecs[i].exp_id));
                check($sformatf("row%0d core_ready", i), 128'(bus.core_ready_o), 128'(er));
            end
`ifdef FPU_SS_ARB_STATS_EN
            if (!vecs[i].rst_n)
                for (int k = 0; k < N; k++) cnt_model[k] = 0;
            else if (vecs[i].exp_valid && vecs[i].ready && cnt_model[vecs[i].exp_id] < 16'hFFFF)
                cnt_model[vecs[i].exp_id]++;
`endif
        end

        // Back-pressured lock on core 1 with core 0 competing; payload and id held.
        for (int c = 0; c < 3; c++) begin
            drive(1, 8'h03, 0, 8'hA0 + 8'(c));
            $display("hold %0d: id=%0d x_valid=%0b", c, bus.core_id_o, bus.x_issue_valid_o);
            check($sformatf("hold%0d core_id", c), 128'(bus.core_id_o), 128'd1);
            check($sformatf("hold%0d x_issue_req", c), bus.x_issue_req_o, payload(1));
            check($sformatf("hold%0d core_ready", c), 128'(bus.core_ready_o), 128'd0);
        end
        drive(1, 8'h03, 1, 8'h55);
        $display("accept: id=%0d core_ready=%h", bus.core_id_o, bus.core_ready_o);
        check("accept core_ready", 128'(bus.core_ready_o), 128'h02);
        drive(1, 8'h03, 1, 8'h66);
        $display("rotate: id=%0d core_ready=%h", bus.core_id_o, bus.core_ready_o);
        check("rotate core_id", 128'(bus.core_id_o), 128'd0);
        check("rotate core_ready", 128'(bus.core_ready_o), 128'h01);

`ifdef FPU_SS_ARB_STATS_EN
        // Core 4 alone: counter must stick at 0xFFFF after 65537 handshakes.
        drive(0, 8'h00, 0, 8'h00);
        for (int c = 0; c < 65537; c++) drive(1, 8'h10, 1, 8'h00);
        drive(1, 8'h00, 0, 8'h00);
        begin
            logic [127:0] esat;
            esat = '0;
            esat[4*16 +: 16] = 16'hFFFF;
            $display("saturation: grant_cnt=%h", bus.grant_cnt_o);
            check("saturated grant_cnt", bus.grant_cnt_o, esat);
        end
`else
        drive(1, 8'h00, 0, 8'h00);
        $display("stats off: grant_cnt=%h", bus.grant_cnt_o);
        check("stats-off grant_cnt", bus.grant_cnt_o, 128'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
